wb_spi_bridge_cs: RTL and testbench
===================================

// Module: wb_spi_bridge_cs
// PURPOSE
// - Parametrised Wishbone bridge between the I2C-to-Wishbone master and the simple_spi_top register port.
// - Replaces direct wire-through with a registered request slice, bus-timeout watchdog and local address decode.
// - Owns a chip-select register that drives NUM_CS active-low SPI slave selects.
// - Owns a sticky status register that latches SPI interrupts and timeouts, and drives irq_o.
// PARAMETERS
// AW        8      Wishbone address width, both ports.
// DW        8      Wishbone data width, both ports. Must be >= NUM_CS and >= 2.
// NUM_CS    4      Number of SPI slave-select outputs, 1..DW.
// TIMEOUT   255    Cycles to wait for m_ack_i before aborting. Range 1..2^16-1.
// LOC_BASE  8'h10  Base address of local registers. CSR at LOC_BASE, STAT at LOC_BASE+1.
// PORTS
// clk_i       in   1       Single clock for both Wishbone ports.
// rst_i       in   1       Asynchronous reset, active low.
// s_cyc_i     in   1       Slave port cycle, driven by the I2C-to-WB master.
// s_stb_i     in   1       Slave port strobe.
// s_we_i      in   1       Slave port write enable.
// s_adr_i     in   AW      Slave port address.
// s_dat_i     in   DW      Slave port write data.
// s_dat_o     out  DW      Slave port read data. Valid only while s_ack_o is high.
// s_ack_o     out  1       Normal termination, one-cycle pulse.
// s_err_o     out  1       Error termination on timeout, one-cycle pulse.
// m_cyc_o     out  1       Master port cycle, to the SPI core.
// m_stb_o     out  1       Master port strobe.
// m_we_o      out  1       Master port write enable.
// m_adr_o     out  AW      Master port address.
// m_dat_o     out  DW      Master port write data.
// m_dat_i     in   DW      Master port read data.
// m_ack_i     in   1       Master port acknowledge.
// spi_inta_i  in   1       SPI core interrupt, level.
// ss_n_o      out  NUM_CS  Slave selects, active low. Equal to ~CSR[NUM_CS-1:0].
// irq_o       out  1       Combined interrupt: STAT[0] | STAT[1].
// BEHAVIOUR
// - Reset values:
//   - All s_*_o and m_*_o outputs are 0.
//   - ss_n_o is all ones; CSR=0, STAT=0, irq_o=0, FSM in IDLE.
// - FSM states: IDLE, FWD, LOCAL, RESP.
//   - IDLE: on s_cyc_i&s_stb_i, capture adr/dat/we into the request slice.
//     - Address in LOC_BASE..LOC_BASE+1 -> LOCAL.
//     - Any other address -> FWD, and assert m_cyc_o/m_stb_o from the slice on the next edge.
//   - FWD: hold m_* stable until m_ack_i, and count cycles.
//     - On m_ack_i: latch m_dat_i, drop m_cyc_o/m_stb_o, pulse s_ack_o -> RESP.
//     - Counter reaches TIMEOUT with no ack: drop m_*, pulse s_err_o, set STAT[1] -> RESP.
//     - m_ack_i and timeout in the same cycle: ack wins, no error.
//   - LOCAL: perform the register access, pulse s_ack_o -> RESP. Fixed 2-cycle latency from the strobe edge.
//   - RESP: wait until s_stb_i is low, then -> IDLE. This prevents re-issuing a held strobe.
// - Forwarded latency: request edge + 1 cycle to m_stb_o + SPI ack latency + 1 cycle to s_ack_o.
// - Local registers:
//   - CSR: read/write. Bits at or above NUM_CS read as 0.
//   - STAT[0]: sticky. Set on any clock where spi_inta_i=1.
//   - STAT[1]: sticky timeout flag.
//   - STAT clear: write 1 to a bit to clear it. Set wins over clear in the same cycle.
//   - Other STAT bits read as 0.
// - Access outside the local window and unmapped on the SPI side is forwarded unchanged; the SPI core decodes it.
// - s_cyc_i dropped mid-FWD: the master cycle still completes or times out.
//   - The resulting s_ack_o/s_err_o pulse is suppressed (not driven).
// - Reset asserted mid-operation: immediate return to reset values. ss_n_o deasserts asynchronously.
// - s_ack_o and s_err_o are never high together.
// STRUCTURE
// - Package wb_bridge_pkg holds the FSM state enum and the STAT bit indices (STAT_INTA=0, STAT_TMO=1).
// - One sub-module, wb_timeout_ctr: load/enable/expire counter, width $clog2(TIMEOUT+1).
// TESTING
// 1. Reset release: ss_n_o=4'hF, irq_o=0, no m_stb_o activity.
// 2. Write 8'h5A to addr 0x01, SPI acks after 3 cycles:
//    - m_adr_o=0x01, m_dat_o=0x5A, m_we_o=1.
//    - Single s_ack_o pulse 1 cycle after m_ack_i.
// 3. Write CSR=8'h05, then read CSR:
//    - ss_n_o=4'b1010; read returns 8'h05; no m_cyc_o pulse.
// 4. Forward read with no m_ack_i, TIMEOUT=8:
//    - s_err_o pulse at cycle 9 after m_stb_o; STAT=8'h02; irq_o=1.
//    - Write 8'h02 to STAT -> irq_o=0.
// 5. spi_inta_i pulse of 1 cycle -> STAT[0]=1 and irq_o=1 persist until a W1C write.
//    - inta held high during that W1C write -> bit stays set.
// 6. Assert rst_i low during FWD -> all outputs return to reset values next sample; the next transaction works normally.

Source files
------------

// File: rtl/wb_bridge_pkg.sv
// Shared types for the Wishbone-to-SPI bridge: FSM state encoding and status bit positions.
package wb_bridge_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_LOCAL, ST_RESP} state_e;

  localparam int STAT_INTA = 0;
  localparam int STAT_TMO  = 1;
endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus watchdog: cleared by load, counts while enabled and saturates at TIMEOUT.
module wb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);
  localparam int            CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                     r_cnt <= '0;
    else if (i_load)                  r_cnt <= '0;
    else if (i_en && (r_cnt != LIMIT)) r_cnt <= r_cnt + 1'b1;
  end

  assign o_expire = (r_cnt == LIMIT);
endmodule

// File: rtl/wb_spi_bridge_cs.sv
// Registered Wishbone bridge to the SPI core with timeout watchdog, a local
// chip-select register driving active-low slave selects, and a sticky status/IRQ register.
module wb_spi_bridge_cs
  import wb_bridge_pkg::*;
#(
  parameter int             AW       = 8,
  parameter int             DW       = 8,
  parameter int             NUM_CS   = 4,
  parameter int             TIMEOUT  = 255,
  parameter logic [AW-1:0]  LOC_BASE = AW'('h10)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_cyc_i,
  input  logic              s_stb_i,
  input  logic              s_we_i,
  input  logic [AW-1:0]     s_adr_i,
  input  logic [DW-1:0]     s_dat_i,
  output logic [DW-1:0]     s_dat_o,
  output logic              s_ack_o,
  output logic              s_err_o,
  output logic              m_cyc_o,
  output logic              m_stb_o,
  output logic              m_we_o,
  output logic [AW-1:0]     m_adr_o,
  output logic [DW-1:0]     m_dat_o,
  input  logic [DW-1:0]     m_dat_i,
  input  logic              m_ack_i,
  input  logic              spi_inta_i,
  output logic [NUM_CS-1:0] ss_n_o,
  output logic              irq_o
);
  localparam logic [AW-1:0] LOC_STAT = LOC_BASE + AW'(1);
  localparam logic [DW-1:0] CS_MASK  = {DW{1'b1}} >> (DW - NUM_CS);

  state_e        r_state, w_state_nxt;
  logic          r_mstb, w_mstb_nxt;
  logic          r_sack, w_sack_nxt;
  logic          r_serr, w_serr_nxt;
  logic          r_we, r_drop;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_dat, r_sdat, r_csr, r_stat, w_stat_nxt, w_loc_rd;
  logic          w_cap, w_loc_acc, w_rd_cap, w_tmo_set, w_expire, w_hit, w_drop, w_stat_wr;

  wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .i_clk    (clk_i),
    .i_rst_n  (rst_i),
    .i_load   (r_state == ST_IDLE),
    .i_en     (r_state == ST_FWD),
    .o_expire (w_expire)
  );

  assign w_hit  = (s_adr_i == LOC_BASE) || (s_adr_i == LOC_STAT);
  // Once the requester abandons the cycle, its termination pulse must not be driven.
  assign w_drop = r_drop | ~s_cyc_i;

  always_comb begin
    w_state_nxt = r_state;
    w_mstb_nxt  = r_mstb;
    w_sack_nxt  = 1'b0;
    w_serr_nxt  = 1'b0;
    w_cap       = 1'b0;
    w_loc_acc   = 1'b0;
    w_rd_cap    = 1'b0;
    w_tmo_set   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          w_cap = 1'b1;
          if (w_hit) begin
            w_state_nxt = ST_LOCAL;
          end else begin
            w_state_nxt = ST_FWD;
            w_mstb_nxt  = 1'b1;
          end
        end
      end
      ST_FWD: begin
        // Acknowledge takes priority over an expiry landing on the same edge.
        if (m_ack_i) begin
          w_mstb_nxt  = 1'b0;
          w_rd_cap    = 1'b1;
          w_sack_nxt  = ~w_drop;
          w_state_nxt = ST_RESP;
        end else if (w_expire) begin
          w_mstb_nxt  = 1'b0;
          w_tmo_set   = 1'b1;
          w_serr_nxt  = ~w_drop;
          w_state_nxt = ST_RESP;
        end
      end
      ST_LOCAL: begin
        w_loc_acc   = 1'b1;
        w_sack_nxt  = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (!s_stb_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_loc_rd  = (r_adr == LOC_BASE) ? r_csr : r_stat;
  assign w_stat_wr = w_loc_acc && r_we && (r_adr == LOC_STAT);

  // Set beats write-one-to-clear when both hit the same bit on one edge.
  always_comb begin
    w_stat_nxt            = '0;
    w_stat_nxt[STAT_INTA] = spi_inta_i |
                            (r_stat[STAT_INTA] & ~(w_stat_wr & r_dat[STAT_INTA]));
    w_stat_nxt[STAT_TMO]  = w_tmo_set |
                            (r_stat[STAT_TMO] & ~(w_stat_wr & r_dat[STAT_TMO]));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_mstb  <= 1'b0;
      r_sack  <= 1'b0;
      r_serr  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mstb  <= w_mstb_nxt;
      r_sack  <= w_sack_nxt;
      r_serr  <= w_serr_nxt;
      if (w_cap)                                r_drop <= 1'b0;
      else if ((r_state == ST_FWD) && !s_cyc_i) r_drop <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_we   <= 1'b0;
      r_adr  <= '0;
      r_dat  <= '0;
      r_sdat <= '0;
      r_csr  <= '0;
      r_stat <= '0;
    end else begin
      if (w_cap) begin
        r_we  <= s_we_i;
        r_adr <= s_adr_i;
        r_dat <= s_dat_i;
      end
      if (w_rd_cap)                r_sdat <= m_dat_i;
      else if (w_loc_acc && !r_we) r_sdat <= w_loc_rd;
      if (w_loc_acc && r_we && (r_adr == LOC_BASE)) r_csr <= r_dat & CS_MASK;
      r_stat <= w_stat_nxt;
    end
  end

  assign m_cyc_o = r_mstb;
  assign m_stb_o = r_mstb;
  assign m_we_o  = r_mstb & r_we;
  assign m_adr_o = r_adr;
  assign m_dat_o = r_dat;
  assign s_ack_o = r_sack;
  assign s_err_o = r_serr;
  assign s_dat_o = r_sdat;
  assign ss_n_o  = ~r_csr[NUM_CS-1:0];
  assign irq_o   = r_stat[STAT_INTA] | r_stat[STAT_TMO];
endmodule

// File: tb/tb_wb_spi_bridge_cs.sv
// Bench for wb_spi_bridge_cs: vector table with a response scoreboard and an SPI-side responder model.
module tb_wb_spi_bridge_cs;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       s_cyc_i, s_stb_i, s_we_i;
  logic [7:0] s_adr_i, s_dat_i, s_dat_o;
  logic       s_ack_o, s_err_o;
  logic       m_cyc_o, m_stb_o, m_we_o;
  logic [7:0] m_adr_o, m_dat_o, m_dat_i;
  logic       m_ack_i, spi_inta_i, irq_o;
  logic [3:0] ss_n_o;

  wb_spi_bridge_cs #(.AW(8), .DW(8), .NUM_CS(4), .TIMEOUT(8), .LOC_BASE(8'h10)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_adr_i(s_adr_i),
    .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_ack_o(s_ack_o), .s_err_o(s_err_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .spi_inta_i(spi_inta_i), .ss_n_o(ss_n_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       we;
    logic [7:0] adr;
    logic [7:0] wd;
    int         lat;
    logic       noack;
    logic       inta;
    logic       exp_err;
    logic [7:0] exp_rd;
    int         exp_lat;
    logic       exp_fwd;
    logic [3:0] exp_ssn;
    logic       exp_irq;
  } vec_t;

  typedef struct {
    logic       err;
    logic [7:0] rd;
    logic       chk_rd;
    int         lat;
  } resp_t;

  vec_t        tbl[$];
  resp_t       exp_q[$];
  logic [16:0] exp_fwd_q[$];
  logic [16:0] fwd_q[$];
  logic [7:0]  mem [256];
  int          checks = 0;
  int          errors = 0;
  int          resp_cnt = 0;
  int          ack_lat = 1;
  logic        noack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // SPI-side responder: acks after ack_lat strobed cycles unless noack is set.
  initial begin
    int  wait_cnt;
    logic prev_stb;
    wait_cnt = 0;
    prev_stb = 1'b0;
    m_ack_i  = 1'b0;
    m_dat_i  = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    forever begin
      @(posedge clk_i); #1;
      if (m_stb_o && !prev_stb) fwd_q.push_back({m_we_o, m_adr_o, m_dat_o});
      prev_stb = m_stb_o;
      if (m_ack_i) begin
        m_ack_i  = 1'b0;
        wait_cnt = 0;
      end else if (m_cyc_o && m_stb_o) begin
        wait_cnt++;
        if (!noack && wait_cnt == ack_lat) begin
          m_ack_i = 1'b1;
          m_dat_i = mem[m_adr_o];
          if (m_we_o) mem[m_adr_o] = m_dat_o;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  always @(negedge clk_i) begin
    if (s_ack_o || s_err_o) resp_cnt++;
    if (s_ack_o && s_err_o) begin
      errors++;
      $display("FAIL ack_err_overlap: got ack=1 err=1 required not both");
    end
  end

  task automatic xfer(input logic we, input logic [7:0] adr, input logic [7:0] wd,
                      output logic got_err, output logic [7:0] rd, output int lat,
                      output logic timed_out);
    s_we_i = we; s_adr_i = adr; s_dat_i = wd; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    lat = 0; timed_out = 1'b1; got_err = 1'b0; rd = 8'h00;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk_i); #1;
      lat++;
      if (s_ack_o || s_err_o) begin
        got_err = s_err_o; rd = s_dat_o; timed_out = 1'b0;
        break;
      end
    end
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      vec_t        v;
      resp_t       e;
      logic        got_err, to;
      logic [7:0]  rd;
      int          lat;
      logic [16:0] fe, fa;
      v = tbl[i];
      ack_lat = v.lat; noack = v.noack; spi_inta_i = v.inta;
      exp_q.push_back('{v.exp_err, v.exp_rd, (!v.we && !v.exp_err), v.exp_lat});
      if (v.exp_fwd) exp_fwd_q.push_back({v.we, v.adr, v.wd});
      xfer(v.we, v.adr, v.wd, got_err, rd, lat, to);
      e = exp_q.pop_front();
      if (to) begin
        checks++; errors++;
        $display("FAIL row%0d_resp: got no termination within 50 cycles, required one", i);
      end else begin
        chk($sformatf("row%0d_err", i), 32'(got_err), 32'(e.err));
        chk($sformatf("row%0d_lat", i), 32'(lat), 32'(e.lat));
        if (e.chk_rd) chk($sformatf("row%0d_rdata", i), 32'(rd), 32'(e.rd));
      end
      @(posedge clk_i); #1;
      chk($sformatf("row%0d_pulse", i), {30'd0, s_ack_o, s_err_o}, 32'd0);
      if (v.exp_fwd) begin
        fe = exp_fwd_q.pop_front();
        if (fwd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL row%0d_fwd: got no master strobe, required {we,adr,dat}=0x%0h", i, fe);
        end else begin
          fa = fwd_q.pop_front();
          chk($sformatf("row%0d_fwd", i), 32'(fa), 32'(fe));
        end
      end else begin
        chk($sformatf("row%0d_nofwd", i), 32'(fwd_q.size()), 32'd0);
      end
      chk($sformatf("row%0d_ssn", i), 32'(ss_n_o), 32'(v.exp_ssn));
      chk($sformatf("row%0d_irq", i), 32'(irq_o), 32'(v.exp_irq));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    //                we  adr    wd    lat nack inta err rd     lat fwd ssn   irq
    tbl.push_back('{1'b1, 8'h01, 8'h5A, 3, 1'b0, 1'b0, 1'b0, 8'h00, 4, 1'b1, 4'hF, 1'b0}); // 0
    tbl.push_back('{1'b0, 8'h01, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h5A, 2, 1'b1, 4'hF, 1'b0}); // 1
    tbl.push_back('{1'b1, 8'h10, 8'h05, 0, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b0, 4'hA, 1'b0}); // 2
    tbl.push_back('{1'b0, 8'h10, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h05, 2, 1'b0, 4'hA, 1'b0}); // 3
    tbl.push_back('{1'b1, 8'h10, 8'hFF, 0, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b0, 4'h0, 1'b0}); // 4
    tbl.push_back('{1'b0, 8'h10, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h0F, 2, 1'b0, 4'h0, 1'b0}); // 5
    tbl.push_back('{1'b1, 8'h10, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b0, 4'hF, 1'b0}); // 6
    tbl.push_back('{1'b0, 8'h20, 8'h00, 0, 1'b1, 1'b0, 1'b1, 8'h00,10, 1'b1, 4'hF, 1'b1}); // 7
    tbl.push_back('{1'b0, 8'h11, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h02, 2, 1'b0, 4'hF, 1'b1}); // 8
    tbl.push_back('{1'b1, 8'h11, 8'h02, 0, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b0, 4'hF, 1'b0}); // 9
    tbl.push_back('{1'b0, 8'h11, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b0, 4'hF, 1'b0}); // 10
    tbl.push_back('{1'b0, 8'h0F, 8'h00, 5, 1'b0, 1'b0, 1'b0, 8'hAA, 6, 1'b1, 4'hF, 1'b0}); // 11
    tbl.push_back('{1'b0, 8'h12, 8'h00, 9, 1'b0, 1'b0, 1'b0, 8'hB7,10, 1'b1, 4'hF, 1'b0}); // 12
    tbl.push_back('{1'b0, 8'h11, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h01, 2, 1'b0, 4'hF, 1'b1}); // 13
    tbl.push_back('{1'b1, 8'h11, 8'h01, 0, 1'b0, 1'b1, 1'b0, 8'h00, 2, 1'b0, 4'hF, 1'b1}); // 14
    tbl.push_back('{1'b0, 8'h11, 8'h00, 0, 1'b0, 1'b1, 1'b0, 8'h01, 2, 1'b0, 4'hF, 1'b1}); // 15
    tbl.push_back('{1'b1, 8'h11, 8'h01, 0, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b0, 4'hF, 1'b0}); // 16
    tbl.push_back('{1'b0, 8'h11, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b0, 4'hF, 1'b0}); // 17
    tbl.push_back('{1'b1, 8'h11, 8'h02, 0, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b0, 4'hF, 1'b0}); // 18
    tbl.push_back('{1'b1, 8'h10, 8'h03, 0, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b0, 4'hC, 1'b0}); // 19
    tbl.push_back('{1'b1, 8'h03, 8'h33, 2, 1'b0, 1'b0, 1'b0, 8'h00, 3, 1'b1, 4'hF, 1'b0}); // 20
    tbl.push_back('{1'b0, 8'h03, 8'h00, 2, 1'b0, 1'b0, 1'b0, 8'h33, 3, 1'b1, 4'hF, 1'b0}); // 21
    tbl.push_back('{1'b0, 8'h10, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b0, 4'hF, 1'b0}); // 22

    rst_i = 1'b0; s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    s_adr_i = 8'h00; s_dat_i = 8'h00; spi_inta_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_outputs", {3'd0, s_ack_o, s_err_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, s_dat_o}, 32'd0);
    chk("rst_ssn", 32'(ss_n_o), 32'hF);
    chk("rst_irq", 32'(irq_o), 32'd0);
    @(negedge clk_i) rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("idle_no_stb", 32'(m_stb_o), 32'd0);
    chk("idle_no_fwd", 32'(fwd_q.size()), 32'd0);

    run_rows(0, 12);

    // One-cycle interrupt pulse must be remembered.
    spi_inta_i = 1'b1;
    @(posedge clk_i); #1;
    spi_inta_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("inta_sticky_irq", 32'(irq_o), 32'd1);
    run_rows(13, 17);

    // Requester abandons a forwarded cycle: master side times out, no pulse back.
    noack = 1'b1;
    rc = resp_cnt;
    s_we_i = 1'b0; s_adr_i = 8'h30; s_dat_i = 8'h00; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("drop_mstb_active", 32'(m_stb_o), 32'd1);
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    repeat (12) @(posedge clk_i);
    #1;
    chk("drop_no_resp", 32'(resp_cnt), 32'(rc));
    chk("drop_mstb_released", 32'(m_stb_o), 32'd0);
    chk("drop_tmo_irq", 32'(irq_o), 32'd1);
    fwd_q.delete();
    noack = 1'b0;
    run_rows(18, 19);

    // Asynchronous reset in the middle of a forwarded cycle.
    noack = 1'b1;
    s_we_i = 1'b0; s_adr_i = 8'h40; s_dat_i = 8'h00; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("midrst_mstb_active", 32'(m_stb_o), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("midrst_outputs", {3'd0, s_ack_o, s_err_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, s_dat_o}, 32'd0);
    chk("midrst_ssn_async", 32'(ss_n_o), 32'hF);
    chk("midrst_irq", 32'(irq_o), 32'd0);
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i); #1;
    noack = 1'b0;
    fwd_q.delete();
    run_rows(20, 22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
